// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared MIPS opcode, funct and ALU control code definitions
package ex_stage_pkg;

    // Primary opcodes used by the decoder
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct field values
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // ALU control codes produced by the decoder and consumed by the execute stage
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] ALU_EQ   = 5'd10;
    localparam logic [4:0] ALU_NEQ  = 5'd11;
    localparam logic [4:0] ALU_GE   = 5'd12;
    localparam logic [4:0] ALU_GEU  = 5'd13;
    localparam logic [4:0] ALU_ADDU = 5'd14;
    localparam logic [4:0] ALU_BEQ  = 5'd15;
    localparam logic [4:0] ALU_BNE  = 5'd16;

    // True for the two codes that resolve a conditional branch
    function automatic logic is_branch_code(input logic [4:0] code);
        return (code == ALU_BEQ) || (code == ALU_BNE);
    endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// rtl/ex_stage_alu.sv - combinational ALU with branch condition and signed overflow
module alu
    import ex_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [4:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [4:0]       i_shamt,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cond,
    output logic             o_ovf
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ovf;
    logic             w_sub_ovf;
    logic             w_eq;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_eq   = (i_a == i_b);

    // Same-sign operands giving a differently signed sum
    assign w_add_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
    // Opposite-sign operands where the difference flips away from A's sign
    assign w_sub_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);

    // Function select; flags stay 0 for every code that does not define them
    always_comb begin
        o_result = '0;
        o_cond   = 1'b0;
        o_ovf    = 1'b0;
        case (i_ctrl)
            ALU_ADD: begin
                o_result = w_sum;
                o_ovf    = w_add_ovf;
            end
            ALU_SUB: begin
                o_result = w_diff;
                o_ovf    = w_sub_ovf;
            end
            ALU_ADDU: o_result = w_sum;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_b) >>> i_shamt);
            ALU_EQ:   o_result = {{(WIDTH-1){1'b0}}, w_eq};
            ALU_NEQ:  o_result = {{(WIDTH-1){1'b0}}, ~w_eq};
            ALU_GE:   o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) >= $signed(i_b))};
            ALU_GEU:  o_result = {{(WIDTH-1){1'b0}}, (i_a >= i_b)};
            ALU_BEQ: begin
                o_cond   = w_eq;
                o_result = {{(WIDTH-1){1'b0}}, w_eq};
            end
            ALU_BNE: begin
                o_cond   = ~w_eq;
                o_result = {{(WIDTH-1){1'b0}}, ~w_eq};
            end
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with ALU, branch resolution and EX/MEM register
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             ex_i_clk,
    input  logic             ex_i_rst_n,
    input  logic             ex_i_valid,
    input  logic             ex_i_stall,
    input  logic             ex_i_flush,
    input  logic [4:0]       ex_i_alu_ctrl,
    input  logic [WIDTH-1:0] ex_i_op_a,
    input  logic [WIDTH-1:0] ex_i_op_b,
    input  logic [4:0]       ex_i_shamt,
    input  logic [WIDTH-1:0] ex_i_pc_plus4,
    input  logic [WIDTH-1:0] ex_i_imm,
    input  logic [WIDTH-1:0] ex_i_store_data,
    input  logic [4:0]       ex_i_rd_addr,
    input  logic             ex_i_reg_write,
    input  logic             ex_i_mem_read,
    input  logic             ex_i_mem_write,
    output logic             ex_o_valid,
    output logic [WIDTH-1:0] ex_o_result,
    output logic [WIDTH-1:0] ex_o_store_data,
    output logic [4:0]       ex_o_rd_addr,
    output logic             ex_o_reg_write,
    output logic             ex_o_mem_read,
    output logic             ex_o_mem_write,
    output logic             ex_o_branch_taken,
    output logic [WIDTH-1:0] ex_o_branch_target,
    output logic             ex_o_ovf
);

    logic [WIDTH-1:0] w_alu_result;
    logic             w_alu_cond;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_target;
    logic             w_taken;
    logic             w_ovf;
    logic             w_reg_write;

    logic             r_valid;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_store_data;
    logic [4:0]       r_rd_addr;
    logic             r_reg_write;
    logic             r_mem_read;
    logic             r_mem_write;
    logic             r_taken;
    logic [WIDTH-1:0] r_target;
    logic             r_ovf;

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_ctrl   (ex_i_alu_ctrl),
        .i_a      (ex_i_op_a),
        .i_b      (ex_i_op_b),
        .i_shamt  (ex_i_shamt),
        .o_result (w_alu_result),
        .o_cond   (w_alu_cond),
        .o_ovf    (w_alu_ovf)
    );

    // Branch target wraps modulo 2^WIDTH; the immediate is already sign-extended
    assign w_target = ex_i_pc_plus4 + (ex_i_imm << 2);

    // Only a valid BEQ/BNE can redirect fetch
    assign w_taken = ex_i_valid & is_branch_code(ex_i_alu_ctrl) & w_alu_cond;

    // Overflow traps only pure register-writing arithmetic, never loads or stores
    assign w_ovf = ex_i_valid & w_alu_ovf & ex_i_reg_write & ~ex_i_mem_read & ~ex_i_mem_write;

    // An overflowing instruction must not commit its result to the register file
    assign w_reg_write = ex_i_valid & ex_i_reg_write & ~w_ovf;

    // EX/MEM register: reset, then flush (bubble), then stall (hold), then load
    always_ff @(posedge ex_i_clk or negedge ex_i_rst_n) begin
        if (!ex_i_rst_n) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
            r_ovf        <= 1'b0;
        end else if (ex_i_flush) begin
            r_valid      <= 1'b0;
            r_result     <= '0;
            r_store_data <= '0;
            r_rd_addr    <= '0;
            r_reg_write  <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_taken      <= 1'b0;
            r_target     <= '0;
            r_ovf        <= 1'b0;
        end else if (!ex_i_stall) begin
            r_valid      <= ex_i_valid;
            r_result     <= w_alu_result;
            r_store_data <= ex_i_store_data;
            r_rd_addr    <= ex_i_rd_addr;
            r_reg_write  <= w_reg_write;
            r_mem_read   <= ex_i_valid & ex_i_mem_read;
            r_mem_write  <= ex_i_valid & ex_i_mem_write;
            r_taken      <= w_taken;
            r_target     <= w_target;
            r_ovf        <= w_ovf;
        end
    end

    assign ex_o_valid         = r_valid;
    assign ex_o_result        = r_result;
    assign ex_o_store_data    = r_store_data;
    assign ex_o_rd_addr       = r_rd_addr;
    assign ex_o_reg_write     = r_reg_write;
    assign ex_o_mem_read      = r_mem_read;
    assign ex_o_mem_write     = r_mem_write;
    assign ex_o_branch_taken  = r_taken;
    assign ex_o_branch_target = r_target;
    assign ex_o_ovf           = r_ovf;

endmodule
